// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_sequencer_if
// Request/response bundle between the control unit and the ALU sequencer.
//
//   Request side  : in_valid, in_ready, in_opcode[4:0], in_ra[31:0],
//                   in_rb[31:0], in_brn
//   Response side : out_valid, out_ready, z_hi[31:0], z_lo[31:0]
//
// Modports:
//   master - the control unit (drives requests, consumes results)
//   slave  - the sequencer   (accepts requests, produces results)
// ----------------------------------------------------------------------------
interface alu_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [31:0] in_ra;
    logic [31:0] in_rb;
    logic        in_brn;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_hi;
    logic [31:0] z_lo;

    modport master (
        output in_valid, in_opcode, in_ra, in_rb, in_brn, out_ready,
        input  in_ready, out_valid, z_hi, z_lo
    );

    modport slave (
        input  in_valid, in_opcode, in_ra, in_rb, in_brn, out_ready,
        output in_ready, out_valid, z_hi, z_lo
    );
endinterface

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer
// Multi-cycle controller in front of a combinational 32-bit ALU. Accepts one
// operation at a time, drives registered opcode/operands/branch flag into the
// ALU, holds them for an opcode-dependent settle time, then captures the
// 64-bit ALU result into the Z pair and offers it on a valid/ready handshake.
//
// Ports:
//   clk          system clock, rising edge
//   clr          synchronous active-high reset (priority over everything)
//   bus          alu_sequencer_if.slave (request in, result out)
//   alu_opcode   registered opcode to the ALU   (reset 5'b11001 = nop)
//   alu_ra/rb    registered operands to the ALU (reset 0)
//   alu_brn      registered branch flag to ALU  (reset 0)
//   alu_rc       64-bit ALU result
//   halted       sticky, set once a halt opcode retires; cleared by clr
//   illegal_op   (ALU_SEQ_ILLEGAL_TRAP_EN only) high while an undefined
//                opcode (11011..11111) sits in DONE
//
// Build option:
//   ALU_SEQ_ILLEGAL_TRAP_EN - undefined opcodes bypass EXEC, leave Z as is
//                             and flag illegal_op. Undefined: they run the
//                             normal BASE_LAT path and capture alu_rc.
// ----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int MUL_LAT  = 4,
    parameter int DIV_LAT  = 34,
    parameter int BASE_LAT = 1
) (
    input  logic             clk,
    input  logic             clr,
    alu_sequencer_if.slave   bus,
    output logic [4:0]       alu_opcode,
    output logic [31:0]      alu_ra,
    output logic [31:0]      alu_rb,
    output logic             alu_brn,
    input  logic [63:0]      alu_rc,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    output logic             illegal_op,
`endif
    output logic             halted
);

    localparam logic [4:0] OP_MUL      = 5'b01110;
    localparam logic [4:0] OP_DIV      = 5'b01111;
    localparam logic [4:0] OP_NOP      = 5'b11001;
    localparam logic [4:0] OP_HALT     = 5'b11010;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    localparam logic [4:0] OP_UNDEF_LO = 5'b11011;
`endif

    localparam int MAX_LAT_MD = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int MAX_LAT    = (MAX_LAT_MD > BASE_LAT) ? MAX_LAT_MD : BASE_LAT;
    // Counter only ever holds lat-1, so clog2(MAX_LAT) bits are enough.
    localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2,
        S_HALT = 2'd3
    } state_t;

    // Settle count loaded on accept: EXEC lasts exactly lat cycles.
    function automatic logic [CNT_W-1:0] settle_count(input logic [4:0] op);
        logic [CNT_W-1:0] c;
        case (op)
            OP_MUL:  c = CNT_W'(MUL_LAT - 1);
            OP_DIV:  c = CNT_W'(DIV_LAT - 1);
            default: c = CNT_W'(BASE_LAT - 1);
        endcase
        return c;
    endfunction

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [4:0]       op_q,        op_d;
    logic [31:0]      ra_q,        ra_d;
    logic [31:0]      rb_q,        rb_d;
    logic             brn_q,       brn_d;
    logic [63:0]      z_q,         z_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             halted_q,    halted_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic             illegal_q,   illegal_d;
`endif

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        ra_d        = ra_q;
        rb_d        = rb_q;
        brn_d       = brn_q;
        z_d         = z_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    op_d       = bus.in_opcode;
                    ra_d       = bus.in_ra;
                    rb_d       = bus.in_rb;
                    brn_d      = bus.in_brn;
                    cnt_d      = settle_count(bus.in_opcode);
                    in_ready_d = 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    // Undefined opcodes never touch the ALU result path.
                    if (bus.in_opcode >= OP_UNDEF_LO) begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        illegal_d   = 1'b1;
                    end else begin
                        state_d     = S_EXEC;
                    end
`else
                    state_d    = S_EXEC;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_EXEC: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    if (op_q == OP_HALT) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d     = S_DONE;
                        out_valid_d = 1'b1;
                        // nop retires through DONE but keeps the old Z.
                        if (op_q != OP_NOP) begin
                            z_d = alu_rc;
                        end else begin
                            z_d = z_q;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
                    illegal_d   = 1'b0;
`endif
                end else begin
                    state_d = S_DONE;
                end
            end

            S_HALT: begin
                state_d = S_HALT;
            end

            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; clr returns everything to reset values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            op_q        <= OP_NOP;
            ra_q        <= 32'd0;
            rb_q        <= 32'd0;
            brn_q       <= 1'b0;
            z_q         <= 64'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ra_q        <= ra_d;
            rb_q        <= rb_d;
            brn_q       <= brn_d;
            z_q         <= z_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.z_hi      = z_q[63:32];
    assign bus.z_lo      = z_q[31:0];
    assign alu_opcode    = op_q;
    assign alu_ra        = ra_q;
    assign alu_rb        = rb_q;
    assign alu_brn       = brn_q;
    assign halted        = halted_q;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    assign illegal_op    = illegal_q;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_sequencer
// Self-checking bench for alu_sequencer. Contains a behavioural ALU whose
// result is only valid once its inputs have been stable for the opcode's
// settle time (garbage before), a reference for expected Z/latency, a
// directed table, hand-written halt / abort sequences and random traffic.
// ----------------------------------------------------------------------------
module tb_alu_sequencer;

    localparam int T_MUL  = 4;
    localparam int T_DIV  = 34;
    localparam int T_BASE = 1;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_MUL  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_BRN  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11001;
    localparam logic [4:0] OP_HALT = 5'b11010;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    alu_sequencer_if bus ();

    logic [4:0]  alu_opcode;
    logic [31:0] alu_ra, alu_rb;
    logic        alu_brn;
    logic [63:0] alu_rc;
    logic        halted;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    alu_sequencer #(.MUL_LAT(T_MUL), .DIV_LAT(T_DIV), .BASE_LAT(T_BASE)) dut (
        .clk        (clk),
        .clr        (clr),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_ra     (alu_ra),
        .alu_rb     (alu_rb),
        .alu_brn    (alu_brn),
        .alu_rc     (alu_rc),
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        .illegal_op (illegal_op),
`endif
        .halted     (halted)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference functions ----------------
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic brn);
        logic [63:0] r;
        case (op)
            5'b00011: r = {32'd0, a + b};
            5'b00100: r = {32'd0, a - b};
            5'b00101: r = {32'd0, a & b};
            5'b00110: r = {32'd0, a | b};
            5'b01110: r = 64'(a) * 64'(b);
            5'b01111: r = (b == 32'd0) ? 64'd0 : {a % b, a / b};
            5'b10010: r = {63'd0, brn};
            5'b11011, 5'b11100, 5'b11101, 5'b11110, 5'b11111: r = 64'd0;
            default:  r = {32'd0, a ^ b};
        endcase
        return r;
    endfunction

    function automatic int settle_of(input logic [4:0] op);
        if (op == OP_MUL) return T_MUL;
        else if (op == OP_DIV) return T_DIV;
        else return T_BASE;
    endfunction

    function automatic bit is_undef(input logic [4:0] op);
        return op >= 5'b11011;
    endfunction

    // Cycles from accept edge to the edge where out_valid rises.
    function automatic int ref_lat(input logic [4:0] op);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (is_undef(op)) return 0;
`endif
        return settle_of(op);
    endfunction

    // Z after the op retires, given Z before it.
    function automatic logic [63:0] ref_z(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic brn,
                                          input logic [63:0] prev);
        if (op == OP_NOP) return prev;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (is_undef(op)) return prev;
`endif
        return ref_alu(op, a, b, brn);
    endfunction

    // ---------------- slow behavioural ALU ----------------
    logic [4:0]  seen_op;
    logic [31:0] seen_ra, seen_rb;
    logic        seen_brn;
    int          age = 0;
    logic        changed;

    assign changed = {alu_opcode, alu_ra, alu_rb, alu_brn} !== {seen_op, seen_ra, seen_rb, seen_brn};

    // Tracks how many edges the ALU inputs have been stable.
    always @(posedge clk) begin
        seen_op  <= alu_opcode;
        seen_ra  <= alu_ra;
        seen_rb  <= alu_rb;
        seen_brn <= alu_brn;
        if (changed) age <= 1;
        else if (age < 1000) age <= age + 1;
    end

    // Result is garbage until the inputs have settled long enough.
    always_comb begin
        if (settle_of(alu_opcode) <= 1 ||
            (!changed && age >= settle_of(alu_opcode) - 1))
            alu_rc = ref_alu(alu_opcode, alu_ra, alu_rb, alu_brn);
        else
            alu_rc = 64'hDEAD_BEEF_0BAD_F00D;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: bound expired", name);
    endtask

    // One complete transaction with busy-time noise and result backpressure.
    task automatic do_req(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic brn, input int hold,
                          input logic [63:0] exp_z, input int exp_lat);
        int k;
        logic bad;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (bus.in_ready !== 1'b1) begin
            fail_now({tag, " in_ready wait"});
            return;
        end
        bus.in_valid  = 1'b1;
        bus.in_opcode = op;
        bus.in_ra     = a;
        bus.in_rb     = b;
        bus.in_brn    = brn;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        chk({tag, " alu_opcode"}, 64'(alu_opcode), 64'(op));
        chk({tag, " alu_ra"}, 64'(alu_ra), 64'(a));
        chk({tag, " alu_rb"}, 64'(alu_rb), 64'(b));
        bad = 1'b0;
        k = 0;
        while (bus.out_valid !== 1'b1 && k < 200) begin
            if (alu_opcode !== op || alu_ra !== a || alu_rb !== b ||
                alu_brn !== brn || bus.in_ready !== 1'b0) bad = 1'b1;
            // Requests and out_ready while busy must be ignored.
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.in_opcode = 5'($urandom);
            bus.in_ra     = $urandom;
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            k++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        if (bus.out_valid !== 1'b1) begin
            fail_now({tag, " out_valid wait"});
            return;
        end
        chk({tag, " latency"}, 64'(k), 64'(exp_lat));
        chk({tag, " busy hold"}, 64'(bad), 64'd0);
        chk({tag, " z"}, {bus.z_hi, bus.z_lo}, exp_z);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk({tag, " illegal_op"}, 64'(illegal_op), 64'(is_undef(op)));
`endif
        bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || {bus.z_hi, bus.z_lo} !== exp_z ||
                bus.in_ready !== 1'b0) bad = 1'b1;
        end
        chk({tag, " backpressure"}, 64'(bad), 64'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({tag, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
        chk({tag, " in_ready back"}, 64'(bus.in_ready), 64'd1);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk({tag, " illegal clear"}, 64'(illegal_op), 64'd0);
`endif
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        brn;
        int          hold;
        logic [63:0] exp_z;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [63:0] prev_z;
        logic [4:0]  rop;
        logic [31:0] ra, rb;
        logic        rbrn;
        logic        bad;

        vecs[0] = '{OP_ADD, 32'd5, 32'd7, 1'b0, 0, 64'd12, 1};
        vecs[1] = '{OP_ADD, 32'd1, 32'd1, 1'b0, 0, 64'd2, 1};
        vecs[2] = '{OP_NOP, 32'd9, 32'd9, 1'b0, 0, 64'd2, 1};
        vecs[3] = '{OP_MUL, 32'h0001_0000, 32'h0001_0000, 1'b0, 2, 64'h0000_0001_0000_0000, 4};
        vecs[4] = '{OP_DIV, 32'd100, 32'd7, 1'b0, 10, {32'd2, 32'd14}, 34};
        vecs[5] = '{OP_BRN, 32'd0, 32'd0, 1'b1, 0, 64'd1, 1};
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        vecs[6] = '{5'b11111, 32'd3, 32'd4, 1'b0, 1, 64'd1, 0};
`else
        vecs[6] = '{5'b11111, 32'd3, 32'd4, 1'b0, 1, 64'd0, 1};
`endif

        bus.in_valid  = 1'b0;
        bus.in_opcode = 5'd0;
        bus.in_ra     = 32'd0;
        bus.in_rb     = 32'd0;
        bus.in_brn    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset for two cycles.
        clr = 1'b1;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        chk("reset in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset halted", 64'(halted), 64'd0);
        chk("reset alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
        chk("reset alu_ra_rb", {alu_ra, alu_rb}, 64'd0);
        chk("reset z", {bus.z_hi, bus.z_lo}, 64'd0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        chk("reset illegal_op", 64'(illegal_op), 64'd0);
`endif

        for (int i = 0; i < 7; i++) begin
            do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].brn,
                   vecs[i].hold, vecs[i].exp_z, vecs[i].exp_lat);
        end

        // Halt: sticky until clr, later requests ignored.
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_HALT;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk("halt halted", 64'(halted), 64'd1);
        chk("halt in_ready", 64'(bus.in_ready), 64'd0);
        chk("halt out_valid", 64'(bus.out_valid), 64'd0);
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_ADD;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (halted !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
                alu_opcode !== OP_HALT) bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        chk("halt sticky", 64'(bad), 64'd0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("halt clr halted", 64'(halted), 64'd0);
        chk("halt clr in_ready", 64'(bus.in_ready), 64'd1);
        chk("halt clr z", {bus.z_hi, bus.z_lo}, 64'd0);

        // Abort a divide ten cycles into EXEC.
        do_req("pre-abort add", OP_ADD, 32'd3, 32'd4, 1'b0, 0, 64'd7, 1);
        bus.in_valid  = 1'b1;
        bus.in_opcode = OP_DIV;
        bus.in_ra     = 32'd1000;
        bus.in_rb     = 32'd3;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("abort out_valid", 64'(bus.out_valid), 64'd0);
        chk("abort in_ready", 64'(bus.in_ready), 64'd1);
        chk("abort z", {bus.z_hi, bus.z_lo}, 64'd0);
        chk("abort alu_opcode", 64'(alu_opcode), 64'(OP_NOP));
        chk("abort alu_ra", 64'(alu_ra), 64'd0);
        bad = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || {bus.z_hi, bus.z_lo} !== 64'd0) bad = 1'b1;
        end
        chk("abort no late result", 64'(bad), 64'd0);

        // Random traffic against the reference.
        prev_z = 64'd0;
        for (int n = 0; n < 40; n++) begin
            rop = 5'($urandom_range(0, 31));
            if (rop == OP_HALT) rop = OP_ADD;
            if (n % 5 == 0) rop = OP_MUL;
            ra   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            rbrn = 1'($urandom_range(0, 1));
            do_req($sformatf("rand%0d op%b", n, rop), rop, ra, rb, rbrn,
                   $urandom_range(0, 3), ref_z(rop, ra, rb, rbrn, prev_z), ref_lat(rop));
            prev_z = ref_z(rop, ra, rb, rbrn, prev_z);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
